// File: rtl/zxuno_regport_master.sv
// Initiator side of the ZXUNO internal register bus.
// Decodes Z80 I/O cycles on the register-select and register-data ports,
// holds the selected register number, strobes peripherals on data writes,
// and returns the OR-collected peripheral read data to the CPU.
module zxuno_regport_master #(
  parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
  parameter logic [15:0] DATA_PORT  = 16'hFD3B,
  parameter logic [7:0]  ADDR_RESET = 8'h00,
  parameter logic [7:0]  IDLE_DATA  = 8'hFF
) (
  input  logic        clk,
  input  logic        poweron_rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_oe,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic        zxuno_regrd_end,
  output logic [7:0]  zxuno_wdata,
  input  logic [7:0]  per_din,
  input  logic        per_oe
);

  logic acc_rd;
  logic acc_wr;
  logic rd_ok;
  logic sel_a;
  logic sel_d;
  logic wr_a;
  logic wr_d;
  logic rd_a;
  logic rd_d;

  // History of the previous cycle's accesses, used for edge detection so a
  // long CPU strobe produces a single latch/strobe.
  logic wr_a_q;
  logic wr_d_q;
  logic rd_d_q;

  assign acc_rd = ~iorq_n & ~rd_n;
  assign acc_wr = ~iorq_n & ~wr_n;
  // A write takes priority when both strobes are low, so the read is suppressed.
  assign rd_ok  = acc_rd & ~acc_wr;
  assign sel_a  = (a == ADDR_PORT);
  assign sel_d  = (a == DATA_PORT);
  assign wr_a   = acc_wr & sel_a;
  assign wr_d   = acc_wr & sel_d;
  assign rd_a   = rd_ok & sel_a;
  assign rd_d   = rd_ok & sel_d;

  // Peripherals see the read level in the same cycle so they can drive oe.
  assign zxuno_regrd = rd_d;

  // Register-select latch, write strobe, read-end pulse and access history.
  always_ff @(posedge clk or negedge poweron_rst_n) begin
    if (!poweron_rst_n) begin
      zxuno_addr      <= ADDR_RESET;
      zxuno_wdata     <= 8'h00;
      zxuno_regwr     <= 1'b0;
      zxuno_regrd_end <= 1'b0;
      // Pretend an access was already in progress so a cycle spanning reset
      // release is not mistaken for a fresh one.
      wr_a_q          <= 1'b1;
      wr_d_q          <= 1'b1;
      rd_d_q          <= 1'b1;
    end else begin
      wr_a_q          <= wr_a;
      wr_d_q          <= wr_d;
      rd_d_q          <= rd_d;
      zxuno_regwr     <= wr_d & ~wr_d_q;
      zxuno_regrd_end <= rd_d_q & ~rd_d;
      if (wr_a && !wr_a_q) begin
        zxuno_addr <= cpu_din;
      end
      if (wr_d && !wr_d_q) begin
        zxuno_wdata <= cpu_din;
      end
    end
  end

  // CPU read-back mux: register number, peripheral data, or bus released.
  always_comb begin
    cpu_oe   = 1'b0;
    cpu_dout = 8'hFF;
    if (rd_a) begin
      cpu_oe   = 1'b1;
      cpu_dout = zxuno_addr;
    end else if (rd_d) begin
      cpu_oe   = 1'b1;
      cpu_dout = per_oe ? per_din : IDLE_DATA;
    end
  end

endmodule

// File: tb/tb_zxuno_regport_master.sv
// Directed bench for zxuno_regport_master: a table of per-cycle input
// vectors with hand-computed outputs, plus a reset-during-write sequence.
module tb_zxuno_regport_master;

  logic        clk;
  logic        poweron_rst_n;
  logic [15:0] a;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_oe;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  logic        zxuno_regrd_end;
  logic [7:0]  zxuno_wdata;
  logic [7:0]  per_din;
  logic        per_oe;

  int n_checks;
  int n_fail;

  typedef struct {
    logic        io;
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [7:0]  din;
    logic [7:0]  pdin;
    logic        poe;
    logic [7:0]  e_addr;
    logic        e_regwr;
    logic        e_regrd;
    logic        e_rend;
    logic [7:0]  e_wdata;
    logic        e_oe;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t vecs[$];

  zxuno_regport_master dut (
    .clk             (clk),
    .poweron_rst_n   (poweron_rst_n),
    .a               (a),
    .iorq_n          (iorq_n),
    .rd_n            (rd_n),
    .wr_n            (wr_n),
    .cpu_din         (cpu_din),
    .cpu_dout        (cpu_dout),
    .cpu_oe          (cpu_oe),
    .zxuno_addr      (zxuno_addr),
    .zxuno_regrd     (zxuno_regrd),
    .zxuno_regwr     (zxuno_regwr),
    .zxuno_regrd_end (zxuno_regrd_end),
    .zxuno_wdata     (zxuno_wdata),
    .per_din         (per_din),
    .per_oe          (per_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %02h expected %02h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic io, input logic rd, input logic wr, input logic [15:0] adr,
                     input logic [7:0] din, input logic [7:0] pdin, input logic poe,
                     input logic [7:0] e_addr, input logic e_regwr, input logic e_regrd,
                     input logic e_rend, input logic [7:0] e_wdata, input logic e_oe,
                     input logic [7:0] e_dout);
    vec_t v;
    v.io = io; v.rd = rd; v.wr = wr; v.adr = adr; v.din = din; v.pdin = pdin; v.poe = poe;
    v.e_addr = e_addr; v.e_regwr = e_regwr; v.e_regrd = e_regrd; v.e_rend = e_rend;
    v.e_wdata = e_wdata; v.e_oe = e_oe; v.e_dout = e_dout;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic io, input logic rd, input logic wr, input logic [15:0] adr,
                       input logic [7:0] din);
    iorq_n  = io;
    rd_n    = rd;
    wr_n    = wr;
    a       = adr;
    cpu_din = din;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Each row: inputs driven just after a rising edge; outputs checked at the
    // following falling edge. Registered outputs reflect the previous row.
    //   io rd wr  a         din    pdin   poe | addr  rwr rrd rend wdata oe dout
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h00, 0, 0, 0, 8'h00, 0, 8'hFF); // 0 idle
    add(0, 1, 0, 16'hFC3B, 8'h0B, 8'h00, 0,   8'h00, 0, 0, 0, 8'h00, 0, 8'hFF); // 1 addr write starts
    add(0, 1, 0, 16'hFC3B, 8'h0B, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 0, 8'hFF); // 2 latched
    add(0, 1, 0, 16'hFC3B, 8'h0C, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 0, 8'hFF); // 3 no relatch
    add(0, 1, 0, 16'hFC3B, 8'h0D, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 0, 8'hFF); // 4
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 0, 8'hFF); // 5
    add(0, 0, 1, 16'hFC3B, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 1, 8'h0B); // 6 addr read
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 0, 8'hFF); // 7
    add(0, 1, 0, 16'hFD3B, 8'hA5, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h00, 0, 8'hFF); // 8 data write
    add(0, 1, 0, 16'hFD3B, 8'hA5, 8'h00, 0,   8'h0B, 1, 0, 0, 8'hA5, 0, 8'hFF); // 9 strobe
    add(0, 1, 0, 16'hFD3B, 8'h5A, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 10
    add(0, 1, 0, 16'hFD3B, 8'h5A, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 11
    add(0, 1, 0, 16'hFD3B, 8'h5A, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 12
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 13
    add(0, 0, 1, 16'hFD3B, 8'h00, 8'h3C, 1,   8'h0B, 0, 1, 0, 8'hA5, 1, 8'h3C); // 14 data read
    add(0, 0, 1, 16'hFD3B, 8'h00, 8'h3C, 1,   8'h0B, 0, 1, 0, 8'hA5, 1, 8'h3C); // 15
    add(0, 0, 1, 16'hFD3B, 8'h00, 8'h3C, 1,   8'h0B, 0, 1, 0, 8'hA5, 1, 8'h3C); // 16
    add(1, 1, 1, 16'h0000, 8'h00, 8'h3C, 1,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 17
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 1, 8'hA5, 0, 8'hFF); // 18 read end
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 19
    add(0, 0, 1, 16'hFD3B, 8'h00, 8'h3C, 0,   8'h0B, 0, 1, 0, 8'hA5, 1, 8'hFF); // 20 unclaimed read
    add(0, 0, 1, 16'hFD3B, 8'h00, 8'h00, 0,   8'h0B, 0, 1, 0, 8'hA5, 1, 8'hFF); // 21
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 22
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 1, 8'hA5, 0, 8'hFF); // 23 read end
    add(0, 1, 0, 16'hFD3B, 8'h11, 8'h00, 0,   8'h0B, 0, 0, 0, 8'hA5, 0, 8'hFF); // 24 write #1
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 1, 0, 0, 8'h11, 0, 8'hFF); // 25
    add(0, 1, 0, 16'hFD3B, 8'h22, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h11, 0, 8'hFF); // 26 write #2
    add(0, 1, 0, 16'h00FE, 8'h99, 8'h00, 0,   8'h0B, 1, 0, 0, 8'h22, 0, 8'hFF); // 27 foreign write
    add(0, 0, 1, 16'h00FE, 8'h00, 8'h55, 1,   8'h0B, 0, 0, 0, 8'h22, 0, 8'hFF); // 28 foreign read
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h22, 0, 8'hFF); // 29
    add(0, 1, 0, 16'hFC3B, 8'h44, 8'h00, 0,   8'h0B, 0, 0, 0, 8'h22, 0, 8'hFF); // 30 addr write
    add(0, 1, 0, 16'hFD3B, 8'h55, 8'h00, 0,   8'h44, 0, 0, 0, 8'h22, 0, 8'hFF); // 31 port switch
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h44, 1, 0, 0, 8'h55, 0, 8'hFF); // 32
    add(0, 0, 0, 16'hFD3B, 8'h66, 8'h3C, 1,   8'h44, 0, 0, 0, 8'h55, 0, 8'hFF); // 33 rd+wr low
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h44, 1, 0, 0, 8'h66, 0, 8'hFF); // 34
    add(1, 1, 1, 16'h0000, 8'h00, 8'h00, 0,   8'h44, 0, 0, 0, 8'h66, 0, 8'hFF); // 35

    // Power-on reset with idle bus.
    poweron_rst_n = 1'b0;
    drive(1, 1, 1, 16'h0000, 8'h00);
    per_din = 8'h00;
    per_oe  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr",  0, zxuno_addr, 8'h00);
    check("rst_regwr", 0, {7'd0, zxuno_regwr}, 8'h00);
    check("rst_oe",    0, {7'd0, cpu_oe}, 8'h00);
    check("rst_dout",  0, cpu_dout, 8'hFF);
    check("rst_wdata", 0, zxuno_wdata, 8'h00);
    poweron_rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("idle_addr",  0, zxuno_addr, 8'h00);
    check("idle_regwr", 0, {7'd0, zxuno_regwr}, 8'h00);
    check("idle_rend",  0, {7'd0, zxuno_regrd_end}, 8'h00);

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].io, vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].din);
      per_din = vecs[i].pdin;
      per_oe  = vecs[i].poe;
      @(negedge clk);
      check("addr",  i, zxuno_addr, vecs[i].e_addr);
      check("regwr", i, {7'd0, zxuno_regwr}, {7'd0, vecs[i].e_regwr});
      check("regrd", i, {7'd0, zxuno_regrd}, {7'd0, vecs[i].e_regrd});
      check("rend",  i, {7'd0, zxuno_regrd_end}, {7'd0, vecs[i].e_rend});
      check("wdata", i, zxuno_wdata, vecs[i].e_wdata);
      check("oe",    i, {7'd0, cpu_oe}, {7'd0, vecs[i].e_oe});
      check("dout",  i, cpu_dout, vecs[i].e_dout);
    end

    // Reset asserted together with a write to the select port, released while
    // the strobe is still active: nothing must latch.
    @(posedge clk);
    #1;
    drive(0, 1, 0, 16'hFC3B, 8'h77);
    poweron_rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_addr", 100, zxuno_addr, 8'h00);
    @(posedge clk);
    #1;
    poweron_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rel_addr",  101 + k, zxuno_addr, 8'h00);
      check("rel_regwr", 101 + k, {7'd0, zxuno_regwr}, 8'h00);
      @(posedge clk);
      #1;
    end
    drive(1, 1, 1, 16'h0000, 8'h00);
    @(posedge clk);
    #1;
    drive(0, 1, 0, 16'hFC3B, 8'h12);
    @(negedge clk);
    check("fresh_pre", 110, zxuno_addr, 8'h00);
    @(posedge clk);
    #1;
    drive(1, 1, 1, 16'h0000, 8'h00);
    @(negedge clk);
    check("fresh_addr",  111, zxuno_addr, 8'h12);
    check("fresh_regwr", 111, {7'd0, zxuno_regwr}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/zxuno_regport_master.md
Name: zxuno_regport_master

Overview:
- Initiator side of the ZXUNO internal register bus.
- Decodes Z80 I/O cycles on the address port (default FC3B) and the data port (default FD3B).
- Holds the selected register number and drives zxuno_addr, zxuno_regrd and zxuno_regwr to every register peripheral.
- Returns the OR-collected peripheral read data to the CPU data bus.
- Sits between the CPU bus glue and all ZXUNO register blocks.

Parameters:
- ADDR_PORT, 16'hFC3B, full 16-bit I/O address of the register-select port.
- DATA_PORT, 16'hFD3B, full 16-bit I/O address of the register-data port.
- ADDR_RESET, 8'h00, value of zxuno_addr after reset.
- IDLE_DATA, 8'hFF, value returned on a data-port read when no peripheral claims the register.

Ports:
- clk  in  1  system clock. All CPU inputs are synchronous to it; no synchronizers.
- poweron_rst_n  in  1  asynchronous, active-low reset.
- a  in  16  CPU address bus.
- iorq_n  in  1  CPU I/O request, active low.
- rd_n  in  1  CPU read strobe, active low.
- wr_n  in  1  CPU write strobe, active low.
- cpu_din  in  8  data driven by the CPU.
- cpu_dout  out  8  data returned to the CPU.
- cpu_oe  out  1  high when cpu_dout must be placed on the CPU bus.
- zxuno_addr  out  8  currently selected register number.
- zxuno_regrd  out  1  level, high during a data-port read cycle.
- zxuno_regwr  out  1  single-cycle write strobe.
- zxuno_regrd_end  out  1  single-cycle pulse after a data-port read cycle ends; lets side-effecting registers pop or clear.
- zxuno_wdata  out  8  write data to peripherals, held stable.
- per_din  in  8  OR of all peripheral dout values, gated by each peripheral's oe.
- per_oe  in  1  OR of all peripheral oe.

Behaviour:
- Decodes, all combinational:
  - acc_rd = ~iorq_n & ~rd_n
  - acc_wr = ~iorq_n & ~wr_n
  - sel_a = (a == ADDR_PORT)
  - sel_d = (a == DATA_PORT)
- History registers: wr_a_q, wr_d_q and rd_d_q hold the previous-cycle values of acc_wr&sel_a, acc_wr&sel_d and acc_rd&sel_d.
- Reset (async, poweron_rst_n = 0):
  - zxuno_addr = ADDR_RESET; zxuno_wdata = 8'h00.
  - zxuno_regwr = 0; zxuno_regrd_end = 0.
  - wr_a_q, wr_d_q and rd_d_q are set to 1. An I/O cycle still in progress when reset deasserts therefore produces no latch and no strobe.
- Address write: on the first clk edge where acc_wr&sel_a = 1 and wr_a_q = 0, zxuno_addr <= cpu_din. The new value is visible on the next cycle. The rest of the same I/O cycle leaves it unchanged.
- Data write: on the first edge where acc_wr&sel_d = 1 and wr_d_q = 0:
  - zxuno_wdata <= cpu_din.
  - zxuno_regwr <= 1 for exactly one cycle (registered, 1-cycle latency).
  - zxuno_addr is unchanged.
  - Exactly one regwr pulse per CPU I/O cycle, however long the cycle lasts.
- Data read:
  - zxuno_regrd = acc_rd&sel_d, combinational and level, so peripherals can drive oe within the same cycle.
  - The cycle after acc_rd&sel_d falls (rd_d_q = 1 and the current value = 0), zxuno_regrd_end <= 1 for one cycle.
- cpu_dout / cpu_oe, combinational:
  - Address-port read: cpu_oe = 1, cpu_dout = zxuno_addr.
  - Data-port read: cpu_oe = 1, cpu_dout = per_oe ? per_din : IDLE_DATA.
  - Otherwise: cpu_oe = 0, cpu_dout = 8'hFF.
- Boundary cases:
  - Back-to-back I/O cycles separated by at least one cycle with the strobe deasserted each produce their own strobe.
  - A change of a during an active strobe, from one port to the other, counts as a new access to the new port.
  - rd_n and wr_n both low: write decoding takes priority. zxuno_regrd is forced to 0 and cpu_oe to 0.
  - Accesses to any other port are ignored; no output changes.
- No other state. zxuno_addr persists indefinitely and wraps naturally over 00..FF.

Test Plan:
- Reset, then hold idle -> zxuno_addr = 8'h00, zxuno_regwr = 0, cpu_oe = 0, cpu_dout = 8'hFF.
- Write 8'h0B to FC3B, strobe held 4 cycles -> zxuno_addr = 8'h0B from the cycle after the first active edge; no regwr pulse. Then read FC3B -> cpu_oe = 1, cpu_dout = 8'h0B.
- Address 8'h0B, write 8'hA5 to FD3B with a 5-cycle strobe -> exactly one zxuno_regwr pulse, 1 cycle after the strobe starts; zxuno_wdata = 8'hA5.
- Read FD3B with per_oe = 1, per_din = 8'h3C -> zxuno_regrd high for the full strobe; cpu_dout = 8'h3C; one zxuno_regrd_end pulse on the cycle after the strobe ends. Repeat with per_oe = 0 -> cpu_dout = 8'hFF.
- Assert poweron_rst_n low mid-write to FC3B with cpu_din = 8'h77, release while the strobe is still active -> zxuno_addr stays 8'h00, no regwr pulse. The next fresh write latches normally.
- Two FD3B writes separated by one idle cycle, plus an access to 00FE -> exactly two regwr pulses; the 00FE access changes nothing.
